mbist_fail_logger: RTL and testbench
====================================

// Module: mbist_fail_logger
// PURPOSE
//  Receiving end of the BIST compare path. It captures every read-compare mismatch produced
//  during a self-test run: address, expected data, actual data and pattern index.
//  Entries go into a small first-word-fall-through FIFO with a valid/ready drain port, so a
//  host or debug controller can read out failing cells after or during the run.
//  It also keeps a saturating fail count, a sticky fail flag and an overflow flag.
// PARAMETERS
//  ADDR_W  6  width of captured RAM address
//  DATA_W  8  width of expected/actual data words
//  PAT_W   3  width of pattern index (decoder select bits)
//  DEPTH   4  FIFO entries; power of 2, >=2
//  CNT_W   8  width of saturating fail counter
// PORTS
//  clk          in   1        clock, all state on posedge
//  rst          in   1        asynchronous, active-high reset
//  clr          in   1        synchronous clear; same effect as rst, applied at the clock edge
//  test_active  in   1        high while BIST owns the RAM (NbarT)
//  cmp_valid    in   1        compare strobe; cmp_* fields valid this cycle
//  cmp_addr     in   ADDR_W   address being checked
//  cmp_exp      in   DATA_W   expected pattern data
//  cmp_act      in   DATA_W   data read from RAM
//  cmp_pat      in   PAT_W    pattern index
//  rd_ready     in   1        drain side accepts head entry
//  rd_valid     out  1        FIFO non-empty; head entry presented
//  rd_addr      out  ADDR_W   head entry address
//  rd_exp       out  DATA_W   head entry expected data
//  rd_act       out  DATA_W   head entry actual data
//  rd_pat       out  PAT_W    head entry pattern index
//  rd_syn       out  DATA_W   rd_exp ^ rd_act (failing-bit syndrome)
//  fail_sticky  out  1        at least one mismatch seen in the current run
//  fail_count   out  CNT_W    number of mismatches in the run; saturates at all-ones
//  overflow     out  1        sticky; a mismatch was dropped because the FIFO was full
//  logging      out  1        high in state LOG
// BEHAVIOUR
//  Reset and clear:
//   - rst (async) or clr (sync) -> state IDLE, FIFO empty, all outputs 0.
//   - rd_* outputs read 0 when the FIFO is empty.
//   - rst asserted mid-run discards all entries immediately.
//  State machine (IDLE, LOG, HOLD):
//   - IDLE -> LOG when test_active=1. Entering LOG clears the FIFO, fail_count, fail_sticky and overflow.
//   - LOG -> HOLD when test_active=0. All results are frozen.
//   - HOLD -> LOG when test_active=1. This starts a new run and clears everything as above.
//   - HOLD persists otherwise. IDLE persists while test_active=0.
//  Mismatch detection:
//   - mismatch = state==LOG && cmp_valid && (cmp_exp != cmp_act).
//   - Strobes in the IDLE/HOLD cycle where test_active first rises are ignored, because state is not yet LOG.
//  On a mismatch:
//   - fail_count increments, saturating.
//   - fail_sticky goes to 1.
//   - The entry is pushed if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
//   - Otherwise the entry is dropped and overflow is set to 1.
//  Latency:
//   - A mismatch sampled at edge N gives rd_valid=1 and updated fail_count/fail_sticky after edge N.
//   - When the FIFO was empty, the entry is visible on rd_* in the cycle after edge N.
//  Drain:
//   - pop = rd_valid && rd_ready, allowed in LOG and HOLD. In IDLE the FIFO is always empty.
//   - rd_* are driven combinationally from the head storage slot (FWFT) and are stable while rd_valid && !rd_ready.
//   - rd_ready while empty has no effect.
//  Simultaneous push and pop:
//   - Occupancy is unchanged.
//   - Order is strict FIFO; a new entry never overtakes an older one.
//  Pointers and occupancy:
//   - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//   - Occupancy is tracked with a log2(DEPTH)+1-bit counter; full when count==DEPTH.
//  Other rules:
//   - logging = (state==LOG).
//   - clr takes priority over all other same-cycle events.
// TESTING
//  1 Clean run: test_active=1 for 64 strobes, exp==act -> rd_valid=0, fail_count=0, fail_sticky=0, overflow=0.
//  2 Single fault: mismatch at addr 6'h15, exp 8'hAA, act 8'hA8, pat 0 -> next cycle rd_valid=1,
//    rd_addr=15, rd_syn=8'h02, fail_count=1; pop with rd_ready -> rd_valid=0.
//  3 Overflow: 6 mismatches, DEPTH=4, rd_ready=0 -> fail_count=6, overflow=1; drain returns first 4 in order.
//  4 Full + simultaneous pop: FIFO full, mismatch with rd_ready=1 in the same cycle -> overflow stays 0,
//    occupancy stays 4, new entry is last out.
//  5 Run restart: HOLD with 2 entries, test_active rises -> after entry to LOG, FIFO empty, fail_count=0;
//    strobe on the rising cycle ignored.
//  6 Async rst mid-LOG with 3 entries -> rd_valid=0, counters 0, state IDLE, without waiting for a clock edge;
//    saturation check with CNT_W=2: 5 mismatches -> fail_count=3.

Source files
------------

// File: rtl/mbist_fail_logger.sv
// mbist_fail_logger: captures BIST read-compare mismatches into a small
// first-word-fall-through FIFO with a valid/ready drain port, and keeps a
// saturating fail count, a sticky fail flag and a sticky overflow flag.
module mbist_fail_logger #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int PAT_W  = 3,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              test_active,
    input  logic              cmp_valid,
    input  logic [ADDR_W-1:0] cmp_addr,
    input  logic [DATA_W-1:0] cmp_exp,
    input  logic [DATA_W-1:0] cmp_act,
    input  logic [PAT_W-1:0]  cmp_pat,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_exp,
    output logic [DATA_W-1:0] rd_act,
    output logic [PAT_W-1:0]  rd_pat,
    output logic [DATA_W-1:0] rd_syn,
    output logic              fail_sticky,
    output logic [CNT_W-1:0]  fail_count,
    output logic              overflow,
    output logic              logging
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + 2 * DATA_W + PAT_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOG,
        S_HOLD
    } state_t;

    state_t             r_state;
    logic [ENT_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [OCC_W-1:0]   r_occ;
    logic [CNT_W-1:0]   r_fail_count;
    logic               r_sticky;
    logic               r_overflow;

    logic               w_run_start;
    logic               w_mismatch;
    logic               w_full;
    logic               w_nonempty;
    logic               w_pop;
    logic               w_push;
    logic [ENT_W-1:0]   w_new_entry;
    logic [ENT_W-1:0]   w_head;

    assign w_run_start = (r_state != S_LOG) && test_active;
    assign w_mismatch  = (r_state == S_LOG) && cmp_valid && (cmp_exp != cmp_act);
    assign w_full      = (r_occ == OCC_W'(DEPTH));
    assign w_nonempty  = (r_occ != '0);
    assign w_pop       = w_nonempty && rd_ready && (r_state != S_IDLE);
    // A full FIFO still accepts a new entry when the head leaves in the same cycle.
    assign w_push      = w_mismatch && (!w_full || w_pop);
    assign w_new_entry = {cmp_addr, cmp_exp, cmp_act, cmp_pat};
    assign w_head      = r_mem[r_rptr];

    // Run-control FSM plus FIFO pointers, occupancy and fail statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_occ        <= '0;
            r_fail_count <= '0;
            r_sticky     <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (clr) begin
            r_state      <= S_IDLE;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_occ        <= '0;
            r_fail_count <= '0;
            r_sticky     <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (w_run_start) begin
            // Entering LOG from IDLE or HOLD starts a fresh run; any pending pop is discarded.
            r_state      <= S_LOG;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_occ        <= '0;
            r_fail_count <= '0;
            r_sticky     <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (r_state == S_LOG && !test_active) begin
                r_state <= S_HOLD;
            end
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (w_pop && !w_push) begin
                r_occ <= r_occ - OCC_W'(1);
            end
            if (w_mismatch) begin
                r_sticky <= 1'b1;
                if (r_fail_count != '1) begin
                    r_fail_count <= r_fail_count + CNT_W'(1);
                end
                if (!w_push) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    // Entry storage; contents only matter while counted as occupied, so no reset.
    always_ff @(posedge clk) begin
        if (w_push && !clr) begin
            r_mem[r_wptr] <= w_new_entry;
        end
    end

    assign rd_valid    = w_nonempty;
    assign rd_addr     = w_nonempty ? w_head[ENT_W-1 -: ADDR_W]                     : '0;
    assign rd_exp      = w_nonempty ? w_head[PAT_W+2*DATA_W-1 -: DATA_W]            : '0;
    assign rd_act      = w_nonempty ? w_head[PAT_W+DATA_W-1 -: DATA_W]              : '0;
    assign rd_pat      = w_nonempty ? w_head[PAT_W-1:0]                             : '0;
    assign rd_syn      = rd_exp ^ rd_act;
    assign fail_sticky = r_sticky;
    assign fail_count  = r_fail_count;
    assign overflow    = r_overflow;
    assign logging     = (r_state == S_LOG);

endmodule

// File: tb/tb_mbist_fail_logger.sv
// tb_mbist_fail_logger: scoreboard bench for mbist_fail_logger (default
// parameters) with a second CNT_W=2 instance sharing stimulus for saturation.
module tb_mbist_fail_logger;

    typedef struct packed {
        logic [5:0] a;
        logic [7:0] e;
        logic [7:0] x;
        logic [2:0] p;
    } ent_t;

    typedef enum {M_IDLE, M_LOG, M_HOLD} mst_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       test_active;
    logic       cmp_valid;
    logic [5:0] cmp_addr;
    logic [7:0] cmp_exp;
    logic [7:0] cmp_act;
    logic [2:0] cmp_pat;
    logic       rd_ready;

    logic       rd_valid,  u2_rd_valid;
    logic [5:0] rd_addr,   u2_rd_addr;
    logic [7:0] rd_exp,    u2_rd_exp;
    logic [7:0] rd_act,    u2_rd_act;
    logic [2:0] rd_pat,    u2_rd_pat;
    logic [7:0] rd_syn,    u2_rd_syn;
    logic       fail_sticky, u2_fail_sticky;
    logic [7:0] fail_count;
    logic [1:0] u2_fail_count;
    logic       overflow,  u2_overflow;
    logic       logging,   u2_logging;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    mst_t   m_state;
    ent_t   m_q[$];
    int     m_cnt;
    int     m_cnt2;
    logic   m_sticky;
    logic   m_ovf;

    mbist_fail_logger #(.ADDR_W(6), .DATA_W(8), .PAT_W(3), .DEPTH(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .test_active(test_active),
        .cmp_valid(cmp_valid), .cmp_addr(cmp_addr), .cmp_exp(cmp_exp),
        .cmp_act(cmp_act), .cmp_pat(cmp_pat), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_exp(rd_exp), .rd_act(rd_act),
        .rd_pat(rd_pat), .rd_syn(rd_syn), .fail_sticky(fail_sticky),
        .fail_count(fail_count), .overflow(overflow), .logging(logging)
    );

    mbist_fail_logger #(.ADDR_W(6), .DATA_W(8), .PAT_W(3), .DEPTH(4), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .clr(clr), .test_active(test_active),
        .cmp_valid(cmp_valid), .cmp_addr(cmp_addr), .cmp_exp(cmp_exp),
        .cmp_act(cmp_act), .cmp_pat(cmp_pat), .rd_ready(rd_ready),
        .rd_valid(u2_rd_valid), .rd_addr(u2_rd_addr), .rd_exp(u2_rd_exp), .rd_act(u2_rd_act),
        .rd_pat(u2_rd_pat), .rd_syn(u2_rd_syn), .fail_sticky(u2_fail_sticky),
        .fail_count(u2_fail_count), .overflow(u2_overflow), .logging(u2_logging)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic ent_t mk(input logic [5:0] a, input logic [7:0] e,
                                input logic [7:0] x, input logic [2:0] p);
        ent_t r;
        r.a = a; r.e = e; r.x = x; r.p = p;
        return r;
    endfunction

    task automatic m_reset();
        m_state  = M_IDLE;
        m_q.delete();
        m_cnt    = 0;
        m_cnt2   = 0;
        m_sticky = 1'b0;
        m_ovf    = 1'b0;
    endtask

    task automatic check_all(input string pfx);
        check({pfx, "_valid"}, rd_valid, (m_q.size() != 0));
        if (m_q.size() != 0) begin
            check({pfx, "_addr"}, rd_addr, m_q[0].a);
            check({pfx, "_syn"},  rd_syn,  m_q[0].e ^ m_q[0].x);
        end else begin
            check({pfx, "_addr0"}, rd_addr, 0);
            check({pfx, "_act0"},  rd_act,  0);
        end
        check({pfx, "_count"},  fail_count,    m_cnt);
        check({pfx, "_count2"}, u2_fail_count, m_cnt2);
        check({pfx, "_sticky"}, fail_sticky,   m_sticky);
        check({pfx, "_ovf"},    overflow,      m_ovf);
        check({pfx, "_log"},    logging,       (m_state == M_LOG));
    endtask

    // One clock cycle: drive at negedge, score pops, update model at posedge.
    task automatic cyc(input logic ta, input logic v, input ent_t en, input logic rdy,
                       input logic c);
        logic pop, push, mis, start;
        @(negedge clk);
        test_active = ta; cmp_valid = v; rd_ready = rdy; clr = c;
        cmp_addr = en.a; cmp_exp = en.e; cmp_act = en.x; cmp_pat = en.p;
        start = ta && (m_state != M_LOG);
        pop = (m_q.size() != 0) && rdy && (m_state != M_IDLE) && !c && !start;
        if (pop) begin
            check("sb_valid", rd_valid, 1);
            check("sb_addr",  rd_addr,  m_q[0].a);
            check("sb_exp",   rd_exp,   m_q[0].e);
            check("sb_act",   rd_act,   m_q[0].x);
            check("sb_pat",   rd_pat,   m_q[0].p);
            check("sb_syn",   rd_syn,   m_q[0].e ^ m_q[0].x);
        end
        @(posedge clk);
        if (c) begin
            m_reset();
        end else if (start) begin
            m_reset();
            m_state = M_LOG;
        end else begin
            mis  = (m_state == M_LOG) && v && (en.e != en.x);
            push = mis && ((m_q.size() < 4) || pop);
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back(en);
            if (mis) begin
                m_sticky = 1'b1;
                if (m_cnt  < 255) m_cnt++;
                if (m_cnt2 < 3)   m_cnt2++;
                if (!push) m_ovf = 1'b1;
            end
            if (m_state == M_LOG && !ta) m_state = M_HOLD;
        end
        #1;
        check_all("cyc");
    endtask

    task automatic new_run();
        cyc(1'b0, 1'b0, mk(0, 0, 0, 0), 1'b0, 1'b0);
        cyc(1'b1, 1'b0, mk(0, 0, 0, 0), 1'b0, 1'b0);
    endtask

    task automatic drain(input logic ta);
        for (int i = 0; i < 8 && m_q.size() != 0; i++)
            cyc(ta, 1'b0, mk(0, 0, 0, 0), 1'b1, 1'b0);
    endtask

    initial begin
        int n;
        rst = 1'b1; clr = 1'b0; test_active = 1'b0; cmp_valid = 1'b0; rd_ready = 1'b0;
        cmp_addr = '0; cmp_exp = '0; cmp_act = '0; cmp_pat = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: clean run
        cyc(1'b1, 1'b0, mk(0, 0, 0, 0), 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            cyc(1'b1, 1'b1, mk(6'(i), d, d, 3'(i)), 1'($urandom), 1'b0);
        end
        check("t1_valid", rd_valid, 0);
        check("t1_count", fail_count, 0);
        check("t1_sticky", fail_sticky, 0);
        check("t1_ovf", overflow, 0);

        // 2: single fault
        cyc(1'b1, 1'b1, mk(6'h15, 8'hAA, 8'hA8, 3'd0), 1'b0, 1'b0);
        check("t2_valid", rd_valid, 1);
        check("t2_addr", rd_addr, 6'h15);
        check("t2_syn", rd_syn, 8'h02);
        check("t2_count", fail_count, 1);
        cyc(1'b1, 1'b0, mk(0, 0, 0, 0), 1'b1, 1'b0);
        check("t2_popped", rd_valid, 0);

        // 3: overflow
        new_run();
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 1'b1, mk(6'(i + 1), 8'h00, 8'(1 << i), 3'(i)), 1'b0, 1'b0);
        check("t3_count", fail_count, 6);
        check("t3_ovf", overflow, 1);
        drain(1'b1);

        // 4: full with simultaneous pop
        new_run();
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 1'b1, mk(6'(i + 8), 8'hF0, 8'(8'hF0 ^ (i + 1)), 3'(i)), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, mk(6'h3F, 8'h55, 8'hAA, 3'd7), 1'b1, 1'b0);
        check("t4_ovf", overflow, 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (!rd_valid) break;
            n++;
            cyc(1'b1, 1'b0, mk(0, 0, 0, 0), 1'b1, 1'b0);
        end
        check("t4_occ", n, 4);

        // 5: run restart from HOLD
        new_run();
        cyc(1'b1, 1'b1, mk(6'h01, 8'h01, 8'h00, 3'd1), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, mk(6'h02, 8'h02, 8'h00, 3'd2), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, mk(0, 0, 0, 0), 1'b0, 1'b0);
        cyc(1'b0, 1'b1, mk(6'h03, 8'h03, 8'h00, 3'd3), 1'b0, 1'b0);
        check("t5_hold_count", fail_count, 2);
        cyc(1'b1, 1'b1, mk(6'h04, 8'h04, 8'h00, 3'd4), 1'b1, 1'b0);
        check("t5_valid", rd_valid, 0);
        check("t5_count", fail_count, 0);
        check("t5_log", logging, 1);
        cyc(1'b1, 1'b1, mk(6'h05, 8'h05, 8'h00, 3'd5), 1'b0, 1'b0);
        drain(1'b0);

        // clr wins over a same-cycle mismatch
        new_run();
        cyc(1'b1, 1'b1, mk(6'h11, 8'h11, 8'h10, 3'd1), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, mk(6'h12, 8'h12, 8'h10, 3'd2), 1'b1, 1'b1);
        check("clr_valid", rd_valid, 0);
        check("clr_log", logging, 0);

        // 6: async reset mid-LOG, then saturation on the CNT_W=2 instance
        cyc(1'b1, 1'b0, mk(0, 0, 0, 0), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b1, mk(6'(i + 32), 8'hC3, 8'h3C, 3'(i)), 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        check("t6_valid", rd_valid, 0);
        check("t6_count", fail_count, 0);
        check("t6_sticky", fail_sticky, 0);
        check("t6_log", logging, 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 1'b0, mk(0, 0, 0, 0), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 1'b1, mk(6'(i), 8'hFF, 8'(i), 3'(i)), 1'b0, 1'b0);
        check("t6_sat2", u2_fail_count, 3);
        check("t6_cnt8", fail_count, 5);
        drain(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
